systolic_skew_feeder: RTL and testbench

Operand sequencer that drives the `a_in_top` / `b_in_left` inputs of `systolic_array_8x8`. It buffers one N×N left operand (A) and one N×N top operand (B), loaded one row per beat. On `start` it emits the diagonally skewed streams cycle by cycle, then holds zeros long enough for the array to finish accumulating, so the array computes C = A×B. It replaces bench-side pre-skewed memories with synthesizable hardware.

---
 rtl/systolic_skew_feeder.sv | 178 +++++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// Operand sequencer for an N x N systolic array: buffers A and B, then streams them diagonally skewed.
// Optional macro SKEW_FEEDER_LOAD_CHECK_EN rejects start until every A and B row has been written.
module systolic_skew_lane #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 8,
  parameter int CW         = 4,
  parameter int LANE       = 0
) (
  input  logic [CW-1:0]                  t,
  input  logic [N-1:0][DATA_WIDTH-1:0]   col_b,
  input  logic [N-1:0][DATA_WIDTH-1:0]   row_a,
  output logic [DATA_WIDTH-1:0]          a_el,
  output logic [DATA_WIDTH-1:0]          b_el
);
  localparam int IW = $clog2(N);

  always_comb begin
    int i;
    logic [IW-1:0] idx;
    a_el = '0;
    b_el = '0;
    i    = int'(t) - LANE;
    idx  = i[IW-1:0];
    if (i >= 0 && i < N) begin
      a_el = col_b[idx];
      b_el = row_a[idx];
    end
  end
endmodule

module systolic_skew_feeder #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic                      load_sel,
  input  logic [$clog2(N)-1:0]      load_row,
  input  logic [N*DATA_WIDTH-1:0]   load_data,
  input  logic                      start,
  output logic                      acc_clr,
  output logic                      busy,
  output logic                      done,
  output logic                      start_err,
  output logic [N*DATA_WIDTH-1:0]   a_in_top,
  output logic [N*DATA_WIDTH-1:0]   b_in_left
);
  localparam int CW = $clog2(2*N);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] t_q, t_d;
  logic [N-1:0][N-1:0][DATA_WIDTH-1:0] a_buf_q, a_buf_d, b_buf_q, b_buf_d;
  logic [N-1:0][N-1:0][DATA_WIDTH-1:0] b_col;
  logic [N-1:0][DATA_WIDTH-1:0] a_lane, b_lane;
  logic [N*DATA_WIDTH-1:0] a_top_q, a_top_d, b_left_q, b_left_d;
  logic acc_clr_q, acc_clr_d, busy_q, busy_d, done_q, done_d;
  logic start_err_q, start_err_d, load_ready_q, load_ready_d;
  logic wr_en, start_ok, start_rej;

  assign wr_en = load_valid && load_ready_q;

`ifdef SKEW_FEEDER_LOAD_CHECK_EN
  logic [2*N-1:0] mask_q, mask_d, mask_wr;

  // The write in the same cycle counts toward completeness, matching write-before-start ordering.
  always_comb begin
    mask_wr = mask_q;
    if (wr_en) mask_wr[{load_sel, load_row}] = 1'b1;
    start_ok  = start && (state_q == S_IDLE) && (&mask_wr);
    start_rej = start && (state_q == S_IDLE) && !(&mask_wr);
    mask_d    = start_ok ? '0 : mask_wr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask_q <= '0;
    else     mask_q <= mask_d;
  end
`else
  assign start_ok  = start && (state_q == S_IDLE);
  assign start_rej = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      S_IDLE: if (start_ok) begin
        state_d = S_FEED;
        t_d     = '0;
      end
      S_FEED: if (t_q == CW'(2*N-2)) begin
        state_d = S_DRAIN;
        t_d     = '0;
      end else t_d = t_q + CW'(1);
      S_DRAIN: if (t_q == CW'(N-1)) begin
        state_d = S_IDLE;
        t_d     = '0;
      end else t_d = t_q + CW'(1);
      default: begin
        state_d = S_IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Lanes look at next-cycle buffers and index so outputs land registered one cycle after the edge.
  for (genvar k = 0; k < N; k++) begin : g_lane
    for (genvar r = 0; r < N; r++) begin : g_col
      assign b_col[k][r] = b_buf_d[r][k];
    end
    systolic_skew_lane #(.N(N), .DATA_WIDTH(DATA_WIDTH), .CW(CW), .LANE(k)) u_lane (
      .t     (t_d),
      .col_b (b_col[k]),
      .row_a (a_buf_d[k]),
      .a_el  (a_lane[k]),
      .b_el  (b_lane[k])
    );
  end

  always_comb begin
    a_buf_d = a_buf_q;
    b_buf_d = b_buf_q;
    if (wr_en) begin
      if (load_sel) b_buf_d[load_row] = load_data;
      else          a_buf_d[load_row] = load_data;
    end
    acc_clr_d    = start_ok;
    start_err_d  = start_rej;
    busy_d       = (state_d != S_IDLE);
    load_ready_d = (state_d == S_IDLE);
    done_d       = (state_q == S_DRAIN) && (state_d == S_IDLE);
    a_top_d      = (state_d == S_FEED) ? a_lane : '0;
    b_left_d     = (state_d == S_FEED) ? b_lane : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q          <= '0;
      a_buf_q      <= '0;
      b_buf_q      <= '0;
      a_top_q      <= '0;
      b_left_q     <= '0;
      acc_clr_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_err_q  <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      t_q          <= t_d;
      a_buf_q      <= a_buf_d;
      b_buf_q      <= b_buf_d;
      a_top_q      <= a_top_d;
      b_left_q     <= b_left_d;
      acc_clr_q    <= acc_clr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      start_err_q  <= start_err_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign a_in_top   = a_top_q;
  assign b_in_left  = b_left_q;
  assign acc_clr    = acc_clr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign start_err  = start_err_q;
  assign load_ready = load_ready_q;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: bus spot-checks from a table plus a behavioural array model for C = A x B.
module tb_systolic_skew_feeder;
  localparam int N  = 8;
  localparam int DW = 8;
  localparam int HL = 3*N+2;

  logic clk = 1'b0;
  logic rst, load_valid, load_sel, start;
  logic [$clog2(N)-1:0] load_row;
  logic [N*DW-1:0] load_data;
  logic load_ready, acc_clr, busy, done, start_err;
  logic [N*DW-1:0] a_in_top, b_in_left;

  systolic_skew_feeder #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_sel(load_sel), .load_row(load_row), .load_data(load_data),
    .start(start), .acc_clr(acc_clr), .busy(busy), .done(done),
    .start_err(start_err), .a_in_top(a_in_top), .b_in_left(b_in_left)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int A [N][N];
  int B [N][N];
  logic [N*DW-1:0] ha [0:HL];
  logic [N*DW-1:0] hb [0:HL];
  logic [31:0] busy_m, clr_m, done_m, err_m, rdy_m;

  typedef struct {
    int         off;
    int         lane;
    logic [7:0] ae;
    logic [7:0] be;
    logic       busy_e;
    logic       clr_e;
    logic       done_e;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] pack_row(input int s, input int r);
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) begin
      int x;
      x = (s == 1) ? B[r][k] : A[r][k];
      v[k*DW +: DW] = x[DW-1:0];
    end
    return v;
  endfunction

  function automatic int lane_of(input logic [N*DW-1:0] bus, input int k);
    logic [DW-1:0] e;
    e = bus[k*DW +: DW];
    return int'(e);
  endfunction

  task automatic load_mats(input bit coincide);
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < N; r++) begin
        @(negedge clk);
        load_valid = 1'b1; load_sel = s[0]; load_row = r[2:0]; load_data = pack_row(s, r);
        if (!(coincide && s == 1 && r == N-1)) @(posedge clk);
      end
    if (!coincide) begin
      @(negedge clk);
      load_valid = 1'b0;
    end
  endtask

  // Starts at edge E0 and records cycles E0+1 .. E0+HL; optional busy-time start+write at cycle inj.
  task automatic run_seq(input bit coincide, input int inj);
    if (!coincide) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; load_valid = 1'b0;
    busy_m = '0; clr_m = '0; done_m = '0; err_m = '0; rdy_m = '0;
    for (int c = 1; c <= HL; c++) begin
      @(negedge clk);
      ha[c] = a_in_top; hb[c] = b_in_left;
      busy_m[c] = busy; clr_m[c] = acc_clr; done_m[c] = done; err_m[c] = start_err; rdy_m[c] = load_ready;
      if (c == inj) begin
        start = 1'b1; load_valid = 1'b1; load_sel = 1'b0; load_row = '0; load_data = '1;
      end else if (c == inj + 1) begin
        start = 1'b0; load_valid = 1'b0;
      end
    end
  endtask

  // Feeds the recorded buses through an ideal output-stationary array and compares with A x B.
  task automatic check_product(input string name);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int c_m, c_e;
        c_m = 0; c_e = 0;
        for (int k = 0; k < N; k++) c_e += A[i][k] * B[k][j];
        for (int t = 1; t <= HL + 2*N; t++) begin
          int s1, s2;
          s1 = t - j; s2 = t - i;
          if (s1 >= 1 && s1 <= HL && s2 >= 1 && s2 <= HL)
            c_m += lane_of(hb[s1], i) * lane_of(ha[s2], j);
        end
        chk($sformatf("%s C[%0d][%0d]", name, i, j), 64'(c_m), 64'(c_e));
      end
  endtask

  task automatic check_ctrl(input string name);
    logic [31:0] busy_e, done_e, clr_e, rdy_e;
    busy_e = '0; done_e = '0; clr_e = '0;
    for (int c = 1; c < 3*N; c++) busy_e[c] = 1'b1;
    done_e[3*N] = 1'b1;
    clr_e[1] = 1'b1;
    rdy_e = ~busy_e & 32'h07FF_FFFE;
    chk({name, " busy_mask"}, 64'(busy_m), 64'(busy_e));
    chk({name, " done_mask"}, 64'(done_m), 64'(done_e));
    chk({name, " acc_clr_mask"}, 64'(clr_m), 64'(clr_e));
    chk({name, " ready_mask"}, 64'(rdy_m), 64'(rdy_e));
    chk({name, " start_err_mask"}, 64'(err_m), 64'd0);
  endtask

  initial begin
    vec_t vt [13];
    int seen_done;
    rst = 1'b1; load_valid = 1'b0; load_sel = 1'b0; load_row = '0; load_data = '0; start = 1'b0;

    vt[0]  = '{1,  0, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0};
    vt[1]  = '{1,  1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
    vt[2]  = '{2,  0, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{2,  1, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{3,  1, 8'h09, 8'h01, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{3,  2, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{8,  0, 8'h38, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{8,  7, 8'h07, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{15, 7, 8'h3F, 8'h01, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{15, 6, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[10] = '{16, -1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[11] = '{23, -1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[12] = '{24, -1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst a_in_top", a_in_top, 64'd0);
    chk("rst b_in_left", b_in_left, 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst acc_clr", 64'(acc_clr), 64'd0);
    chk("rst start_err", 64'(start_err), 64'd0);
    chk("rst load_ready", 64'(load_ready), 64'd1);
    rst = 1'b0;

    // Basic product: A = identity, B[r][c] = r*8+c
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        A[r][c] = (r == c) ? 1 : 0;
        B[r][c] = r*8 + c;
      end
    load_mats(1'b0);
    run_seq(1'b0, -1);
    for (int v = 0; v < 13; v++) begin
      if (vt[v].lane < 0) begin
        chk($sformatf("vec%0d a_bus", v), ha[vt[v].off], 64'd0);
        chk($sformatf("vec%0d b_bus", v), hb[vt[v].off], 64'd0);
      end else begin
        chk($sformatf("vec%0d a_lane", v), 64'(lane_of(ha[vt[v].off], vt[v].lane)), 64'(vt[v].ae));
        chk($sformatf("vec%0d b_lane", v), 64'(lane_of(hb[vt[v].off], vt[v].lane)), 64'(vt[v].be));
      end
      chk($sformatf("vec%0d busy", v), 64'(busy_m[vt[v].off]), 64'(vt[v].busy_e));
      chk($sformatf("vec%0d acc_clr", v), 64'(clr_m[vt[v].off]), 64'(vt[v].clr_e));
      chk($sformatf("vec%0d done", v), 64'(done_m[vt[v].off]), 64'(vt[v].done_e));
    end
    check_ctrl("basic");
    check_product("basic");

`ifndef SKEW_FEEDER_LOAD_CHECK_EN
    // Replay without reload
    run_seq(1'b0, -1);
    check_ctrl("replay");
    check_product("replay");
`endif

    // Counting with a start+write attempt while busy
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        A[r][c] = 1;
        B[r][c] = 1;
      end
    load_mats(1'b0);
    run_seq(1'b0, 5);
    check_ctrl("count");
    check_product("count");

    // Reset mid-sequence
    load_mats(1'b0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst a_in_top", a_in_top, 64'd0);
    chk("midrst b_in_left", b_in_left, 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst load_ready", 64'(load_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 3*N + 4; c++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    chk("midrst no_done_no_busy", 64'(seen_done), 64'd0);

`ifndef SKEW_FEEDER_LOAD_CHECK_EN
    // Buffers were cleared by reset
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        A[r][c] = 0;
        B[r][c] = 0;
      end
    run_seq(1'b0, -1);
    check_ctrl("cleared");
    check_product("cleared");
`endif

    // Fresh load, final B row written in the start cycle
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        A[r][c] = (r + 2*c) % 7 + 1;
        B[r][c] = (3*r + c) % 11;
      end
    load_mats(1'b1);
    run_seq(1'b1, -1);
    check_ctrl("fresh");
    check_product("fresh");

`ifdef SKEW_FEEDER_LOAD_CHECK_EN
    // Incomplete load is rejected, completing it allows start
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < N; r++)
        if (!(s == 1 && r == N-1)) begin
          @(negedge clk);
          load_valid = 1'b1; load_sel = s[0]; load_row = r[2:0]; load_data = pack_row(s, r);
          @(posedge clk);
        end
    @(negedge clk);
    load_valid = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("lchk start_err", 64'(start_err), 64'd1);
    chk("lchk busy_rej", 64'(busy), 64'd0);
    @(negedge clk);
    chk("lchk start_err_pulse", 64'(start_err), 64'd0);
    load_valid = 1'b1; load_sel = 1'b1; load_row = 3'(N-1); load_data = pack_row(1, N-1);
    @(posedge clk);
    #1 load_valid = 1'b0;
    run_seq(1'b0, -1);
    check_ctrl("lchk");
    check_product("lchk");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
